conv_layer_sched: RTL and testbench



---
 rtl/conv_layer_sched_if.sv | 32 +++
 rtl/conv_layer_sched.sv | 147 ++++++++++++++
 tb/tb_conv_layer_sched.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_layer_sched_if.sv
// Signal bundle between the layer scheduler and its host / layer engines.
// The scheduler takes the slave modport; the host/engine side takes master.
interface conv_layer_sched_if #(
    parameter int unsigned NUM_LAYERS = 3,
    parameter int unsigned W_AW       = 11,
    parameter int unsigned B_AW       = 7
);
    logic                  start;
    logic                  abort;
    logic [NUM_LAYERS-1:0] layer_valid;
    logic [NUM_LAYERS-1:0] layer_en;
    logic                  layer_clr;
    logic [2:0]            layer_idx;
    logic                  sram_sel;
    logic [W_AW-1:0]       weight_base;
    logic [B_AW-1:0]       bias_base;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start, abort, layer_valid,
        input  layer_en, layer_clr, layer_idx, sram_sel, weight_base, bias_base,
        input  busy, done, err
    );

    modport slave (
        input  start, abort, layer_valid,
        output layer_en, layer_clr, layer_idx, sram_sel, weight_base, bias_base,
        output busy, done, err
    );
endinterface

// File: rtl/conv_layer_sched.sv
// Sequences the convolution layer engines: clear, enable, wait for valid, drain,
// then swap the A/B SRAM ping-pong and advance the weight/bias base addresses.
module conv_layer_sched #(
    parameter int unsigned NUM_LAYERS = 3,
    parameter int unsigned W_AW       = 11,
    parameter int unsigned B_AW       = 7,
    parameter logic [NUM_LAYERS*W_AW-1:0] LAYER_W_WORDS = {11'd36, 11'd72, 11'd144},
    parameter logic [NUM_LAYERS*B_AW-1:0] LAYER_B_WORDS = {7'd4, 7'd8, 7'd16},
    parameter int unsigned DRAIN_CYC  = 4,
    parameter int unsigned WDOG_W     = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    conv_layer_sched_if.slave bus
);
    localparam int unsigned DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [2:0] {StIdle, StClr, StRun, StDrain, StDone, StErr} state_t;

    state_t                r_state;
    logic [WDOG_W-1:0]     r_wdog;
    logic [DCW-1:0]        r_dcnt;
    logic [NUM_LAYERS-1:0] r_en;
    logic                  r_clr;
    logic [2:0]            r_idx;
    logic                  r_sel;
    logic [W_AW-1:0]       r_wbase;
    logic [B_AW-1:0]       r_bbase;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic [NUM_LAYERS-1:0] w_onehot;
    logic                  w_hit;
    logic                  w_last;
    logic                  w_dlast;
    logic                  w_abort;
    logic                  w_wdog_exp;
    logic [W_AW-1:0]       w_wstep;
    logic [B_AW-1:0]       w_bstep;

    always_comb begin
        w_onehot   = NUM_LAYERS'(1) << r_idx;
        // Only the running layer's valid counts; the others are ignored.
        w_hit      = |(bus.layer_valid & w_onehot);
        w_last     = (r_idx == 3'(NUM_LAYERS - 1));
        w_dlast    = (r_dcnt == DCW'(DRAIN_CYC - 1));
        w_abort    = bus.abort && (r_state inside {StClr, StRun, StDrain, StDone});
        w_wdog_exp = (r_wdog == WDOG_W'(1));
        w_wstep    = LAYER_W_WORDS[r_idx*W_AW +: W_AW];
        w_bstep    = LAYER_B_WORDS[r_idx*B_AW +: B_AW];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_wdog  <= '0;
            r_dcnt  <= '0;
            r_en    <= '0;
            r_clr   <= 1'b0;
            r_idx   <= '0;
            r_sel   <= 1'b0;
            r_wbase <= '0;
            r_bbase <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_clr  <= 1'b0;
            r_done <= 1'b0;
            // Abort outranks valid, watchdog expiry and drain completion.
            if (w_abort) begin
                r_state <= StErr;
                r_en    <= '0;
                r_err   <= 1'b1;
                r_busy  <= 1'b1;
            end else begin
                unique case (r_state)
                    StIdle, StErr: begin
                        if (bus.start) begin
                            r_state <= StClr;
                            r_clr   <= 1'b1;
                            r_busy  <= 1'b1;
                            r_err   <= 1'b0;
                            r_idx   <= '0;
                            r_sel   <= 1'b0;
                            r_wbase <= '0;
                            r_bbase <= '0;
                        end
                    end
                    StClr: begin
                        r_state <= StRun;
                        r_en    <= w_onehot;
                        r_wdog  <= '1;
                    end
                    StRun: begin
                        if (w_hit) begin
                            r_state <= StDrain;
                            r_en    <= '0;
                            r_dcnt  <= '0;
                        end else if (w_wdog_exp) begin
                            r_state <= StErr;
                            r_en    <= '0;
                            r_err   <= 1'b1;
                        end else begin
                            r_wdog <= r_wdog - 1'b1;
                        end
                    end
                    StDrain: begin
                        if (!w_dlast) begin
                            r_dcnt <= r_dcnt + 1'b1;
                        end else if (w_last) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= StClr;
                            r_clr   <= 1'b1;
                            r_idx   <= r_idx + 3'd1;
                            r_sel   <= ~r_sel;
                            r_wbase <= r_wbase + w_wstep;
                            r_bbase <= r_bbase + w_bstep;
                        end
                    end
                    StDone: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_idx   <= '0;
                        r_sel   <= 1'b0;
                        r_wbase <= '0;
                        r_bbase <= '0;
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign bus.layer_en    = r_en;
    assign bus.layer_clr   = r_clr;
    assign bus.layer_idx   = r_idx;
    assign bus.sram_sel    = r_sel;
    assign bus.weight_base = r_wbase;
    assign bus.bias_base   = r_bbase;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
endmodule

// File: tb/tb_conv_layer_sched.sv
// Scoreboard bench for conv_layer_sched: a schedule model pushes expected output
// events; a negedge monitor detects DUT events and compares them in order.
module tb_conv_layer_sched;
    localparam int NL = 3;
    localparam int WA = 11;
    localparam int BA = 7;
    localparam int DR = 4;
    localparam int WD = 8;
    localparam int WDOG_RUN = (1 << WD) - 1;
    localparam int EV_CLR = 0, EV_EN = 1, EV_DONE = 2, EV_ERR = 3, EV_IDLE = 4;

    typedef struct {
        int kind;
        int cyc;
        int p0;
        int p1;
        int p2;
        int p3;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   mon_on = 1'b0;
    ev_t  exp_q[$];
    int   dly[NL];
    int   w_words[NL] = '{144, 72, 36};
    int   b_words[NL] = '{16, 8, 4};

    conv_layer_sched_if #(.NUM_LAYERS(NL), .W_AW(WA), .B_AW(BA)) bus ();

    conv_layer_sched #(
        .NUM_LAYERS   (NL),
        .W_AW         (WA),
        .B_AW         (BA),
        .LAYER_W_WORDS({11'd36, 11'd72, 11'd144}),
        .LAYER_B_WORDS({7'd4, 7'd8, 7'd16}),
        .DRAIN_CYC    (DR),
        .WDOG_W       (WD)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input int p0 = 0, input int p1 = 0,
                        input int p2 = 0, input int p3 = 0);
        ev_t e;
        e.kind = kind; e.cyc = c; e.p0 = p0; e.p1 = p1; e.p2 = p2; e.p3 = p3;
        exp_q.push_back(e);
    endtask

    task automatic got(input int kind, input int p0, input int p1, input int p2, input int p3);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d, none expected (cycle %0d)", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("ev_kind", kind, e.kind);
            chk($sformatf("ev%0d_cycle", e.kind), cyc, e.cyc);
            chk($sformatf("ev%0d_p0", e.kind), p0, e.p0);
            chk($sformatf("ev%0d_p1", e.kind), p1, e.p1);
            chk($sformatf("ev%0d_p2", e.kind), p2, e.p2);
            chk($sformatf("ev%0d_p3", e.kind), p3, e.p3);
        end
    endtask

    // Monitor: turns output activity into events and checks them against the queue.
    initial begin
        logic [NL-1:0] pen;
        logic          perr;
        logic          pbusy;
        pen = '0; perr = 1'b0; pbusy = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (bus.layer_clr)
                    got(EV_CLR, int'(bus.layer_idx), int'({bus.layer_en, bus.err, bus.sram_sel}),
                        int'(bus.weight_base), int'(bus.bias_base));
                if (bus.layer_en != pen && bus.layer_en != '0)
                    got(EV_EN, int'(bus.layer_en), int'(bus.layer_idx), 0, 0);
                if (bus.done)
                    got(EV_DONE, int'(bus.busy), int'(bus.layer_en), int'(bus.layer_idx), 0);
                if (bus.err && !perr)
                    got(EV_ERR, int'(bus.layer_en), int'(bus.busy), int'(bus.done), 0);
                if (!bus.busy && pbusy)
                    got(EV_IDLE, int'({bus.layer_en, bus.layer_idx, bus.sram_sel, bus.layer_clr,
                                       bus.done, bus.err}),
                        int'(bus.weight_base), int'(bus.bias_base), 0);
            end
            pen = bus.layer_en; perr = bus.err; pbusy = bus.busy;
        end
    end

    // Reference schedule: start at cycle t, engine k answers dly[k] cycles after enable.
    task automatic plan_run(input int t, input int nlay, input bit finish);
        int c, e, wb, bb;
        c = t + 1; wb = 0; bb = 0;
        for (int k = 0; k < nlay; k++) begin
            push(EV_CLR, c, k, k % 2, wb, bb);
            e = c + 1;
            push(EV_EN, e, 1 << k, k);
            wb = (wb + w_words[k]) % (1 << WA);
            bb = (bb + b_words[k]) % (1 << BA);
            c = e + dly[k] + 1 + DR;
            if (finish && k == NL - 1) begin
                push(EV_DONE, c, 1, 0, NL - 1);
                push(EV_IDLE, c + 1);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_en"}, int'(bus.layer_en), 0);
        chk({tag, "_clr"}, int'(bus.layer_clr), 0);
        chk({tag, "_idx"}, int'(bus.layer_idx), 0);
        chk({tag, "_sel"}, int'(bus.sram_sel), 0);
        chk({tag, "_wbase"}, int'(bus.weight_base), 0);
        chk({tag, "_bbase"}, int'(bus.bias_base), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_err"}, int'(bus.err), 0);
    endtask

    task automatic do_start(output int t);
        @(posedge clk); #1;
        t = cyc;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_en(input int k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.layer_en[k]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL en_timeout: layer %0d enable never seen (cycle %0d)", k, cyc);
        end
    endtask

    // Engine model; mode 1 puts a spurious valid on layer 2 while layer 0 runs,
    // mode 2 adds random valid noise on the non-running layers.
    task automatic engine(input int upto, input int abort_layer, input int mode,
                          output int vcyc);
        bit            ok;
        logic [NL-1:0] oh, n;
        vcyc = 0;
        for (int k = 0; k < upto; k++) begin
            wait_en(k, ok);
            if (!ok) return;
            oh = NL'(1) << k;
            for (int i = 1; i <= dly[k]; i++) begin
                @(posedge clk); #1;
                if (mode == 1) n = (k == 0) ? 3'b100 : 3'b000;
                else if (mode == 2) n = NL'($urandom_range(0, 7));
                else n = '0;
                n = n & ~oh;
                if (i == dly[k]) begin
                    bus.layer_valid = oh | n;
                    if (k == abort_layer) bus.abort = 1'b1;
                    vcyc = cyc;
                end else begin
                    bus.layer_valid = n;
                end
            end
            @(posedge clk); #1;
            bus.layer_valid = '0;
            bus.abort = 1'b0;
        end
    endtask

    task automatic full_run(input int mode);
        int t, v;
        do_start(t);
        plan_run(t, NL, 1'b1);
        engine(NL, -1, mode, v);
        repeat (DR + 6) @(posedge clk);
    endtask

    initial begin
        int t, v, r;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.layer_valid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        mon_on = 1'b1;

        // Nominal: 100-cycle engines, spurious layer-2 valid during layer 0.
        for (int k = 0; k < NL; k++) dly[k] = 100;
        full_run(1);

        // Minimum turnaround, then randomized engine latencies with noise.
        for (int k = 0; k < NL; k++) dly[k] = 1;
        full_run(2);
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < NL; k++) dly[k] = $urandom_range(1, 60);
            full_run(2);
        end

        // Watchdog: layer 0 never answers.
        do_start(t);
        push(EV_CLR, t + 1, 0, 0, 0, 0);
        push(EV_EN, t + 2, 1, 0);
        push(EV_ERR, t + 2 + WDOG_RUN, 0, 1, 0);
        repeat (WDOG_RUN + 10) @(posedge clk);
        @(negedge clk);
        chk("wdog_err", int'(bus.err), 1);
        chk("wdog_en", int'(bus.layer_en), 0);
        chk("wdog_busy", int'(bus.busy), 1);
        for (int k = 0; k < NL; k++) dly[k] = $urandom_range(1, 30);
        full_run(2);

        // Abort coincident with layer 1 valid: straight to ERR, no drain.
        for (int k = 0; k < NL; k++) dly[k] = $urandom_range(2, 30);
        do_start(t);
        plan_run(t, 2, 1'b0);
        engine(2, 1, 0, v);
        push(EV_ERR, v + 1, 0, 1, 0);
        repeat (DR + 10) @(posedge clk);
        @(negedge clk);
        chk("abort_err", int'(bus.err), 1);
        chk("abort_idx", int'(bus.layer_idx), 1);
        full_run(2);

        // Reset in the middle of layer 1.
        for (int k = 0; k < NL; k++) dly[k] = $urandom_range(2, 30);
        do_start(t);
        plan_run(t, 2, 1'b0);
        engine(1, -1, 0, v);
        begin
            bit ok;
            wait_en(1, ok);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        r = cyc;
        push(EV_IDLE, r + 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        for (int k = 0; k < NL; k++) dly[k] = $urandom_range(1, 40);
        full_run(2);

        repeat (20) @(posedge clk);
        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_event: kind %0d expected at cycle %0d never seen", e.kind, e.cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
